// File: rtl/regalu_pkg.sv
// Shared types and constants for the regalu issue path.
// Register 0 is the architectural discard sink and never creates a dependence.
package regalu_pkg;

    localparam logic [2:0] NOP_OP   = 3'b000;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] rr1;
        logic [4:0] rr2;
        logic [4:0] wr;
        logic [2:0] op;
    } issue_req_t;

    typedef struct packed {
        logic       v;
        logic [4:0] wr;
    } sb_entry_t;

    // True when source register r is still being produced by the in-flight entry e.
    function automatic logic sb_hit(input logic [4:0] r, input sb_entry_t e);
        return (r != REG_ZERO) && e.v && (e.wr == r);
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// In-order request queue; head is registered storage, so nothing passes through in the push cycle.
// Push is ignored when full, pop when empty; flush empties the queue and overrides both.
module issue_fifo
    import regalu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  issue_req_t             push_dat,
    output issue_req_t             head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    issue_req_t     mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           push_ok, pop_ok;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign push_ok  = push && !full && !flush;
    assign pop_ok   = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/regalu_issue_ctrl.sv
// Queues ALU ops and issues the head into regalu, stalling on RAW hazards against X/M until write-back.
// Earliest issue is one cycle after acceptance; in_ready drops when full or while flushing.
module regalu_issue_ctrl
    import regalu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rr1,
    input  logic [4:0]       in_rr2,
    input  logic [4:0]       in_wr,
    input  logic [2:0]       in_op,
    input  logic             flush,
    output logic [4:0]       RR1,
    output logic [4:0]       RR2,
    output logic [4:0]       WR,
    output logic [2:0]       INop,
    output logic             issue,
    output logic             busy,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    issue_req_t               in_req, head;
    logic                     fifo_full, fifo_empty, push, hazard, stall_ev;
    logic [$clog2(DEPTH):0]   fifo_cnt;
    sb_entry_t                sbx_q, sbx_d, sbm_q;
    logic [CNT_W-1:0]         issued_cnt_q, issued_cnt_d, stall_cnt_q, stall_cnt_d;

    assign in_req = '{rr1: in_rr1, rr2: in_rr2, wr: in_wr, op: in_op};

    issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (issue),
        .flush    (flush),
        .push_dat (in_req),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // No bypass network: any source still in X or M must wait for write-back.
    always_comb begin
        hazard = sb_hit(head.rr1, sbx_q) || sb_hit(head.rr1, sbm_q) ||
                 sb_hit(head.rr2, sbx_q) || sb_hit(head.rr2, sbm_q);
    end

    always_comb begin
        in_ready = rst_n && !flush && !fifo_full;
        push     = in_valid && in_ready;
        issue    = rst_n && !fifo_empty && !hazard && !flush;
        stall_ev = rst_n && !fifo_empty && hazard && !flush;
        busy     = (fifo_cnt != '0) || sbx_q.v || sbm_q.v;
        RR1      = REG_ZERO;
        RR2      = REG_ZERO;
        WR       = REG_ZERO;
        INop     = NOP_OP;
        if (issue) begin
            RR1  = head.rr1;
            RR2  = head.rr2;
            WR   = head.wr;
            INop = head.op;
        end
    end

    always_comb begin
        sbx_d.v      = issue && (head.wr != REG_ZERO);
        sbx_d.wr     = head.wr;
        issued_cnt_d = issued_cnt_q + (issue    ? CNT_W'(1) : CNT_W'(0));
        stall_cnt_d  = stall_cnt_q  + (stall_ev ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sbx_q        <= '0;
            sbm_q        <= '0;
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            sbx_q        <= sbx_d;
            sbm_q        <= sbx_q;
            issued_cnt_q <= issued_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/regalu_issue_ctrl.md
Name: regalu_issue_ctrl

Overview:
Issue controller in front of the regalu register-file/ALU pipeline. It accepts ALU operations from an upstream requester over a valid/ready handshake and buffers them in a small in-order queue. Each cycle it drives RR1/RR2/WR/INop into regalu, either with the queue head or with a bubble. Without bypass logic in the datapath, it tracks destination registers in flight in the X and M stages and stalls dependent operations until write-back completes.

Parameters:
DEPTH, 4, queue entries; must be a power of two and at least 2.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  request present
in_ready  out  1  queue can accept; transfer occurs when in_valid && in_ready
in_rr1  in  5  source register 1
in_rr2  in  5  source register 2
in_wr  in  5  destination register; 0 means discard
in_op  in  3  ALU opcode
flush  in  1  discard all queued, un-issued requests
RR1  out  5  to regalu RR1
RR2  out  5  to regalu RR2
WR  out  5  to regalu WR
INop  out  3  to regalu INop
issue  out  1  a real operation is driven this cycle
busy  out  1  queue non-empty, or any X/M scoreboard entry valid
issued_cnt  out  CNT_W  operations issued; wraps
stall_cnt  out  CNT_W  hazard-stall cycles; wraps

Behaviour:
Reset (rst_n=0 at an edge):
- Queue empty; scoreboard X and M invalid; both counters 0.
- During reset, in_ready=0, issue=0, and outputs drive a bubble.
- Reset mid-operation drops all queued requests. Operations already inside regalu are not tracked after reset.

Bubble encoding:
- RR1=0, RR2=0, WR=0, INop=NOP_OP.
- Register 0 is the discard sink.

Queue:
- FIFO with DEPTH entries, in-order.
- in_ready = !flush && (count < DEPTH), computed from registered count only.
- No pass-through: an accepted request can issue no earlier than the cycle after acceptance.
- A push and a pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.

Hazard check (combinational, on the queue head):
- hazard = (head.rr1 != 0 && head.rr1 matches a valid X or M dest) || (same for head.rr2).
- A match means equal to sbX.wr with sbX.v, or equal to sbM.wr with sbM.v.
- A destination of 0 never sets scoreboard valid.

Issue:
- issue = queue non-empty && !hazard && !flush.
- When issue=1, outputs = head fields and the head is popped at the edge.
- Otherwise outputs = bubble.
- RR*/WR/INop are combinational from the registered head.

Scoreboard:
- Each edge: sbX <= {issue && head.wr != 0, head.wr}; sbM <= sbX.
- An operation issued in cycle t is in X in t+1 and M in t+2, and writes back at the end of t+2.
- Distance-1 dependence: 2 stall cycles. Distance-2 dependence: 1 stall cycle. Distance ≥3: no stall.

Counters:
- issued_cnt += 1 on each issue.
- stall_cnt += 1 on each cycle with queue non-empty && hazard && !flush.
- Both wrap from all-ones to 0.

Flush:
- Priority over push and issue.
- At the edge, the queue empties: count=0, pointers reset.
- Scoreboard keeps shifting, so in-flight operations complete.
- in_ready=0 during the flush cycle.
- A flush with an empty queue has no effect beyond that.

Simultaneous events:
- Push while full is impossible, because in_ready=0.
- Flush together with in_valid: the request is not accepted.

Decomposition:
- regalu_pkg:
  - NOP_OP = 3'b000 and REG_ZERO = 5'd0.
  - typedef struct packed issue_req_t {rr1, rr2, wr, op} (18 bits).
  - typedef struct packed sb_entry_t {v, wr}.
- Sub-module issue_fifo #(DEPTH): a generic synchronous FIFO of issue_req_t with push, pop, flush, full, empty and count.
- Hazard compare, scoreboard and counters stay in regalu_issue_ctrl.

Test Plan:
- Reset: rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0, WR=0, INop=0, counters 0; in_ready=1 in the first cycle after release.
- Independent ops: push (1,2→3,op1) then (4,5→6,op2) back-to-back -> issue in consecutive cycles, stall_cnt=0, issued_cnt=2.
- Distance-1 RAW: (1,2→3) then (3,4→5) -> two bubble cycles, second op issues 3 cycles after the first, stall_cnt=2.
- Zero register: (1,2→0) then (0,0→7) -> no stall; sbX.v stays 0 after the first op.
- Backpressure: 6 ops (1,1→1) with in_valid held -> in_ready drops when count=4, no request lost, issues spaced 3 cycles apart in order, issued_cnt=6, stall_cnt=10.
- Flush: 3 queued behind a hazard, flush pulsed 1 cycle -> queue empty next cycle, no further issue, busy=0 within 2 cycles, issued_cnt unchanged.
